i2c_reg_sequencer: RTL

Parametrised I2C register-load sequencer, the successor to the fixed-table camera configuration block. It walks an external register table of `LUT_SIZE` entries and issues one write per entry through the byte-level `I2C_Controller` using its GO/END/ACK handshake. Beyond a straight table walk, it supports generic address and data widths, a tick enable from a divider in the same clock domain (no derived clock), on-demand rewrite of a single entry (e.g. exposure) without a full re-sequence, and bounded NACK retry with error reporting.

---
 rtl/i2c_reg_sequencer_if.sv | 38 +++
 rtl/i2c_reg_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer_if.sv
// Sequencer bus: register-table lookup, I2C controller GO/END/ACK handshake,
// single-entry update request and status flags.
interface i2c_reg_sequencer_if #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned REG_W  = 8,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned LUT_W  = REG_W + DATA_W;
  localparam int unsigned XFER_W = 8 + LUT_W;

  logic              iSTART;
  logic              iUPD_VALID;
  logic [IDX_W-1:0]  iUPD_INDEX;
  logic              oUPD_READY;
  logic [IDX_W-1:0]  oLUT_INDEX;
  logic [LUT_W-1:0]  iLUT_DATA;
  logic [XFER_W-1:0] oI2C_DATA;
  logic              oI2C_GO;
  logic              iI2C_END;
  logic              iI2C_ACK;
  logic              oTICK;
  logic              oBUSY;
  logic              oDONE;
  logic              oERR;
  logic [IDX_W-1:0]  oERR_INDEX;

  modport master (
    input  iSTART, iUPD_VALID, iUPD_INDEX, iLUT_DATA, iI2C_END, iI2C_ACK,
    output oUPD_READY, oLUT_INDEX, oI2C_DATA, oI2C_GO, oTICK, oBUSY, oDONE,
           oERR, oERR_INDEX
  );

  modport slave (
    output iSTART, iUPD_VALID, iUPD_INDEX, iLUT_DATA, iI2C_END, iI2C_ACK,
    input  oUPD_READY, oLUT_INDEX, oI2C_DATA, oI2C_GO, oTICK, oBUSY, oDONE,
           oERR, oERR_INDEX
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// I2C register-load sequencer: walks a register table (or rewrites one entry)
// through a byte-level controller. Define I2C_SEQ_RETRY_EN for bounded NACK retry.
module i2c_reg_sequencer #(
  parameter logic [7:0]  SLAVE_ADDR = 8'hBA,
  parameter int unsigned REG_W      = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LUT_SIZE   = 25,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned CLK_DIV    = 2500,
  parameter int unsigned GAP_TICKS  = 2,
`ifdef I2C_SEQ_RETRY_EN
  parameter int unsigned RETRY_MAX  = 3,
`endif
  parameter bit          AUTO_START = 1'b1
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  i2c_reg_sequencer_if.master  bus
);
  localparam int unsigned XFER_W = 8 + REG_W + DATA_W;
  localparam int unsigned CNT_W  = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam int unsigned GAP_W  = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_NEXT} state_t;

  state_t              state_q, state_d;
  logic                one_q, one_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [XFER_W-1:0]   data_q, data_d;
  logic                go_q, go_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                pend_q, pend_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                gap_next_q, gap_next_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick_q, tick_d;

`ifdef I2C_SEQ_RETRY_EN
  localparam int unsigned RTY_W = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    err_idx_q, err_idx_d;
  assign bus.oERR       = err_q;
  assign bus.oERR_INDEX = err_idx_q;
`else
  assign bus.oERR       = 1'b0;
  assign bus.oERR_INDEX = '0;
`endif

  assign bus.oUPD_READY = ready_q;
  assign bus.oLUT_INDEX = idx_q;
  assign bus.oI2C_DATA  = data_q;
  assign bus.oI2C_GO    = go_q;
  assign bus.oTICK      = tick_q;
  assign bus.oBUSY      = busy_q;
  assign bus.oDONE      = done_q;

  // Next-state, divider and output logic
  always_comb begin
    state_d    = state_q;
    one_d      = one_q;
    idx_d      = idx_q;
    data_d     = data_q;
    go_d       = go_q;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    pend_d     = pend_q | bus.iSTART;
    gap_d      = gap_q;
    gap_next_d = gap_next_q;
    cnt_d      = (cnt_q == CNT_W'(CLK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
    tick_d     = (cnt_d == CNT_W'(CLK_DIV - 1));
`ifdef I2C_SEQ_RETRY_EN
    retry_d    = retry_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pend_q || bus.iSTART) begin
          pend_d  = 1'b0;
          one_d   = 1'b0;
          idx_d   = '0;
          state_d = S_LOAD;
        end else if (bus.iUPD_VALID) begin
          ready_d = 1'b1;
          one_d   = 1'b1;
          idx_d   = bus.iUPD_INDEX;
          // Out-of-range entries complete without a transfer
          state_d = (32'(bus.iUPD_INDEX) >= 32'(LUT_SIZE)) ? S_NEXT : S_LOAD;
        end
      end
      S_LOAD: begin
        data_d  = {SLAVE_ADDR, bus.iLUT_DATA};
`ifdef I2C_SEQ_RETRY_EN
        retry_d = '0;
`endif
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (tick_q) begin
          go_d    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick_q && bus.iI2C_END) begin
          go_d    = 1'b0;
          gap_d   = '0;
          state_d = S_GAP;
          if (!bus.iI2C_ACK) begin
            gap_next_d = 1'b1;
          end else begin
`ifdef I2C_SEQ_RETRY_EN
            if (retry_q == RTY_W'(RETRY_MAX - 1)) begin
              err_d      = 1'b1;
              err_idx_d  = idx_q;
              gap_next_d = 1'b1;
            end else begin
              retry_d    = retry_q + RTY_W'(1);
              gap_next_d = 1'b0;
            end
`else
            gap_next_d = 1'b0;
`endif
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_TICKS)) begin
          if (!bus.iI2C_END) state_d = gap_next_q ? S_NEXT : S_ISSUE;
        end else if (tick_q) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_NEXT: begin
        if (one_q || idx_q == IDX_W'(LUT_SIZE - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      one_q      <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      go_q       <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= AUTO_START;
      gap_q      <= '0;
      gap_next_q <= 1'b0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
      retry_q    <= '0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      one_q      <= one_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      go_q       <= go_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      gap_q      <= gap_d;
      gap_next_q <= gap_next_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
`ifdef I2C_SEQ_RETRY_EN
      retry_q    <= retry_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
`endif
    end
  end
endmodule
